// File: rtl/error_settle_monitor.sv
// -----------------------------------------------------------------------------
// error_settle_monitor
//
// Purpose: on-chip "wait for the error to settle" monitor for self-test and
// telemetry. After a start request it blanks for a programmable front porch,
// then watches NUM_CH signed error channels. The run ends in one of two ways:
//   - settled: every channel stays within +/-limit for STABLE_CNT consecutive
//     valid samples;
//   - timed out: a nonzero WATCH timeout expires first.
// The monitor reports the outcome, the settle time and which channels failed.
//
// Optional build macro: SETTLE_HYST_EN
//   When defined, a channel only has to stay within limit + (limit>>1) while a
//   run of in-limit samples is already under way. That wider bound saturates
//   at WIDTH bits.
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_start           one-cycle request, accepted only in IDLE
//   i_abort           return to IDLE at once, overrides everything else
//   i_err_vld         qualifies i_err this cycle
//   i_err             packed signed samples, channel k at [k*WIDTH +: WIDTH]
//   i_limit           unsigned magnitude bound (latched at start)
//   i_porch_cycles    blanking length in cycles (latched at start)
//   i_timeout_cycles  WATCH timeout in cycles, 0 = none (latched at start)
//   o_busy            high during PORCH and WATCH
//   o_done            one-cycle completion pulse
//   o_settled         sticky: run ended by settling
//   o_timed_out       sticky: run ended by timeout
//   o_settle_time     busy cycles from start to settle, saturating
//   o_ch_fail         per-channel out-of-limit bits of the last sample
//                     before a timeout
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results from the last run are held
// PORCH  | blanking down-count, samples ignored
// WATCH  | counting consecutive in-limit samples, timeout running
// DONE   | single cycle with o_done high, then back to IDLE
// -----------------------------------------------------------------------------
module error_settle_monitor #(
    parameter int WIDTH      = 13,
    parameter int NUM_CH     = 1,
    parameter int STABLE_CNT = 16,
    parameter int PORCH_W    = 24,
    parameter int TMO_W      = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_err_vld,
    input  logic [NUM_CH*WIDTH-1:0] i_err,
    input  logic [WIDTH-2:0]        i_limit,
    input  logic [PORCH_W-1:0]      i_porch_cycles,
    input  logic [TMO_W-1:0]        i_timeout_cycles,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_settled,
    output logic                    o_timed_out,
    output logic [TMO_W-1:0]        o_settle_time,
    output logic [NUM_CH-1:0]       o_ch_fail
);

    localparam int               STB_W    = $clog2(STABLE_CNT + 1);
    localparam logic [STB_W-1:0] STB_TERM = STB_W'(STABLE_CNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PORCH = 2'd1,
        S_WATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-2:0]   r_limit;
    logic [PORCH_W-1:0] r_porch_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_tmo_en;
    logic [STB_W-1:0]   r_stable;
    logic [TMO_W-1:0]   r_time_cnt;
    logic [NUM_CH-1:0]  r_last_fail;

    logic               r_busy;
    logic               r_done;
    logic               r_settled;
    logic               r_timed_out;
    logic [TMO_W-1:0]   r_settle_time;
    logic [NUM_CH-1:0]  r_ch_fail;

    logic [WIDTH-1:0]   w_lim_base;
    logic [WIDTH-1:0]   w_thresh;
    logic [NUM_CH-1:0]  w_fail;
    logic               w_in_lim;
    logic               w_accept;
    logic               w_sample;
    logic               w_settle;
    logic               w_tmo_hit;
    logic               w_busy_st;
    logic [TMO_W-1:0]   w_time_inc;
    logic [STB_W-1:0]   w_stable_inc;

    // -------------------------------------------------------------------------
    // Threshold selection
    // -------------------------------------------------------------------------
    assign w_lim_base = {1'b0, r_limit};

`ifdef SETTLE_HYST_EN
    logic [WIDTH:0]   w_hyst_sum;
    logic [WIDTH-1:0] w_lim_hyst;

    assign w_hyst_sum = {1'b0, w_lim_base} + {2'b00, w_lim_base[WIDTH-1:1]};
    assign w_lim_hyst = w_hyst_sum[WIDTH] ? '1 : w_hyst_sum[WIDTH-1:0];
    // The wider bound only holds an existing run; a fresh run still has to
    // start inside the nominal limit.
    assign w_thresh   = (r_stable != '0) ? w_lim_hyst : w_lim_base;
`else
    assign w_thresh   = w_lim_base;
`endif

    // -------------------------------------------------------------------------
    // Per-channel magnitude check. The magnitude is kept in WIDTH unsigned
    // bits, so the most negative sample maps to 2^(WIDTH-1). That value is
    // above any limit the (WIDTH-1)-bit port can express.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [WIDTH-1:0] v_s;
        logic [WIDTH-1:0] v_abs;
        v_s    = '0;
        v_abs  = '0;
        w_fail = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_s       = i_err[k*WIDTH +: WIDTH];
            v_abs     = v_s[WIDTH-1] ? (WIDTH'(0) - v_s) : v_s;
            w_fail[k] = (v_abs > w_thresh);
        end
    end

    assign w_in_lim     = ~|w_fail;
    assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_sample     = (r_state == S_WATCH) && i_err_vld;
    assign w_stable_inc = r_stable + STB_W'(1);
    assign w_settle     = w_sample && w_in_lim && (w_stable_inc == STB_TERM);
    assign w_tmo_hit    = (r_state == S_WATCH) && r_tmo_en && (r_tmo_cnt == TMO_W'(1));
    assign w_busy_st    = (r_state == S_PORCH) || (r_state == S_WATCH);
    assign w_time_inc   = (&r_time_cnt) ? r_time_cnt : (r_time_cnt + TMO_W'(1));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_PORCH;
            S_PORCH: if (r_porch_cnt == '0) w_state_nxt = S_WATCH;
            S_WATCH: if (w_settle || w_tmo_hit) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_PORCH) || (w_state_nxt == S_WATCH);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Counters and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_limit       <= '0;
            r_porch_cnt   <= '0;
            r_tmo_cnt     <= '0;
            r_tmo_en      <= 1'b0;
            r_stable      <= '0;
            r_time_cnt    <= '0;
            r_last_fail   <= '0;
            r_settled     <= 1'b0;
            r_timed_out   <= 1'b0;
            r_settle_time <= '0;
            r_ch_fail     <= '0;
        end else if (i_abort) begin
            // settle_time is deliberately kept so the last good result
            // survives an abort.
            r_settled   <= 1'b0;
            r_timed_out <= 1'b0;
            r_ch_fail   <= '0;
        end else if (w_accept) begin
            r_limit       <= i_limit;
            r_porch_cnt   <= i_porch_cycles;
            r_tmo_cnt     <= i_timeout_cycles;
            r_tmo_en      <= |i_timeout_cycles;
            r_stable      <= '0;
            r_time_cnt    <= '0;
            r_last_fail   <= '0;
            r_settled     <= 1'b0;
            r_timed_out   <= 1'b0;
            r_settle_time <= '0;
            r_ch_fail     <= '0;
        end else begin
            if (w_busy_st) begin
                r_time_cnt <= w_time_inc;
            end
            if ((r_state == S_PORCH) && (r_porch_cnt != '0)) begin
                r_porch_cnt <= r_porch_cnt - PORCH_W'(1);
            end
            // Loaded with the timeout itself; terminal count 1 marks the
            // last WATCH cycle.
            if ((r_state == S_WATCH) && r_tmo_en) begin
                r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
            end
            if (w_sample) begin
                r_stable    <= w_in_lim ? w_stable_inc : '0;
                r_last_fail <= w_fail;
            end
            if (w_settle) begin
                r_settled     <= 1'b1;
                r_settle_time <= w_time_inc;
            end else if (w_tmo_hit) begin
                r_timed_out <= 1'b1;
                r_ch_fail   <= i_err_vld ? w_fail : r_last_fail;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_settled     = r_settled;
    assign o_timed_out   = r_timed_out;
    assign o_settle_time = r_settle_time;
    assign o_ch_fail     = r_ch_fail;

endmodule

// File: tb/tb_error_settle_monitor.sv
`timescale 1ns/1ps
module tb_error_settle_monitor;

    localparam int WIDTH      = 13;
    localparam int NUM_CH     = 3;
    localparam int STABLE_CNT = 16;
    localparam int PORCH_W    = 24;
    localparam int TMO_W      = 12;
    localparam int TMO_MAX    = (1 << TMO_W) - 1;
`ifdef SETTLE_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic                    err_vld;
    logic [NUM_CH*WIDTH-1:0] err;
    logic [WIDTH-2:0]        limit;
    logic [PORCH_W-1:0]      porch_cycles;
    logic [TMO_W-1:0]        timeout_cycles;
    logic                    busy;
    logic                    done;
    logic                    settled;
    logic                    timed_out;
    logic [TMO_W-1:0]        settle_time;
    logic [NUM_CH-1:0]       ch_fail;

    error_settle_monitor #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .STABLE_CNT(STABLE_CNT),
        .PORCH_W(PORCH_W), .TMO_W(TMO_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_err_vld(err_vld), .i_err(err), .i_limit(limit),
        .i_porch_cycles(porch_cycles), .i_timeout_cycles(timeout_cycles),
        .o_busy(busy), .o_done(done), .o_settled(settled),
        .o_timed_out(timed_out), .o_settle_time(settle_time),
        .o_ch_fail(ch_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit settled;
        bit timed_out;
        int stime;
        int ch_fail;
        int busy_len;
    } exp_t;

    // Per-cycle stimulus, index 0 = first busy cycle after start acceptance.
    bit                      vld_q[$];
    logic [NUM_CH*WIDTH-1:0] err_q[$];
    exp_t                    exp_q[$];
    exp_t                    last_e;

    int n_total  = 0;
    int n_bad    = 0;
    int n_done   = 0;
    int busy_cnt = 0;

    function automatic void chk(string name, int act, int expv);
        n_total++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void push_const(int n, bit v, int e0, int e1, int e2);
        logic [NUM_CH*WIDTH-1:0] w;
        w = {e2[WIDTH-1:0], e1[WIDTH-1:0], e0[WIDTH-1:0]};
        for (int i = 0; i < n; i++) begin
            vld_q.push_back(v);
            err_q.push_back(w);
        end
    endfunction

    function automatic void gen_random(int len, int lim, int bad_den, int vld_pct);
        int v [3];
        for (int c = 0; c < len; c++) begin
            for (int k = 0; k < 3; k++) v[k] = int'($urandom_range(2 * lim)) - lim;
            if ($urandom_range(bad_den - 1) == 0) begin
                int k = $urandom_range(2);
                v[k] = lim + 1 + int'($urandom_range(40));
                if ($urandom_range(1) == 1) v[k] = -v[k];
            end
            push_const(1, ($urandom_range(99) < vld_pct), v[0], v[1], v[2]);
        end
    endfunction

    // Reference: walk the WATCH samples with plain integer arithmetic.
    function automatic exp_t model(int lim, int porch, int tmo);
        exp_t e;
        int   stable = 0;
        int   last   = 0;
        e = '{settled: 1'b0, timed_out: 1'b0, stime: 0, ch_fail: 0, busy_len: -1};
        for (int j = 1; porch + j < vld_q.size(); j++) begin
            int c = porch + j;
            if (vld_q[c]) begin
                logic [NUM_CH*WIDTH-1:0] w;
                int thr;
                int f;
                w   = err_q[c];
                thr = lim;
                if (HYST && stable > 0) thr = lim + lim / 2;
                if (thr > (1 << WIDTH) - 1) thr = (1 << WIDTH) - 1;
                f = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    logic signed [WIDTH-1:0] s;
                    int v;
                    s = w[k*WIDTH +: WIDTH];
                    v = s;
                    if (v < 0) v = -v;
                    if (v > thr) f = f | (1 << k);
                end
                last   = f;
                stable = (f == 0) ? stable + 1 : 0;
                if (stable == STABLE_CNT) begin
                    e.settled  = 1'b1;
                    e.busy_len = porch + 1 + j;
                    e.stime    = (e.busy_len > TMO_MAX) ? TMO_MAX : e.busy_len;
                    return e;
                end
            end
            if (tmo != 0 && j == tmo) begin
                e.timed_out = 1'b1;
                e.ch_fail   = last;
                e.busy_len  = porch + 1 + j;
                return e;
            end
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else if (done) begin
            n_done = n_done + 1;
            if (exp_q.size() == 0) begin
                chk("spurious_done", int'(done), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_settled",     int'(settled),     int'(mon_e.settled));
                chk("mon_timed_out",   int'(timed_out),   int'(mon_e.timed_out));
                chk("mon_settle_time", int'(settle_time), mon_e.stime);
                chk("mon_ch_fail",     int'(ch_fail),     mon_e.ch_fail);
                chk("mon_busy_len",    busy_cnt,          mon_e.busy_len);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt = busy_cnt + 1;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic run_case(input int lim, input int porch, input int tmo, input bit start_in_done);
        exp_t e;
        int   n0;
        e      = model(lim, porch, tmo);
        last_e = e;
        if (e.busy_len > 0) exp_q.push_back(e);
        n0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; limit = lim[WIDTH-2:0];
        porch_cycles = porch[PORCH_W-1:0]; timeout_cycles = tmo[TMO_W-1:0];
        @(posedge clk); #1;
        // Scramble the config inputs to prove they were latched.
        start = 1'b0; limit = $urandom; porch_cycles = $urandom; timeout_cycles = $urandom;
        for (int c = 0; c < vld_q.size(); c++) begin
            err_vld = vld_q[c];
            err     = err_q[c];
            start   = start_in_done && (c == e.busy_len);
            @(posedge clk); #1;
        end
        err_vld = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", n_done - n0, (e.busy_len > 0) ? 1 : 0);
        chk("idle_after", int'(busy), 0);
        chk("hold_settled", int'(settled), int'(e.settled));
        chk("hold_timed_out", int'(timed_out), int'(e.timed_out));
        chk("hold_settle_time", int'(settle_time), e.stime);
        chk("hold_ch_fail", int'(ch_fail), e.ch_fail);
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; err_vld = 1'b0; err = '0;
        limit = '0; porch_cycles = '0; timeout_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_timed_out", int'(timed_out), 0);
        chk("rst_settle_time", int'(settle_time), 0);
        chk("rst_ch_fail", int'(ch_fail), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Porch 100 then settle on zero error: 117 busy cycles.
        vld_q.delete(); err_q.delete();
        push_const(101 + 16 + 3, 1'b1, 0, 0, 0);
        run_case(25, 100, 0, 1'b0);

        // Out-of-limit run of 50 resets the stable count.
        vld_q.delete(); err_q.delete();
        push_const(4 + 50, 1'b1, 26, 0, 0);
        push_const(30, 1'b1, 0, 0, 0);
        run_case(25, 3, 0, 1'b0);

        // Timeout with channel 1 stuck out of limit.
        vld_q.delete(); err_q.delete();
        push_const(6 + 1000 + 3, 1'b1, 0, -300, 0);
        run_case(25, 5, 1000, 1'b0);
        pulse_abort();
        chk("abort_idle_timed_out", int'(timed_out), 0);
        chk("abort_idle_ch_fail", int'(ch_fail), 0);
        chk("abort_idle_settle_time", int'(settle_time), 0);

        // Most negative sample always exceeds the largest limit.
        vld_q.delete(); err_q.delete();
        push_const(2 + 60, 1'b1, -4096, 0, 0);
        run_case(4095, 1, 50, 1'b0);

        // Settle on the timeout cycle wins; one cycle earlier times out.
        vld_q.delete(); err_q.delete();
        push_const(3 + 16 + 3, 1'b1, 0, 0, 0);
        run_case(25, 2, 16, 1'b0);
        run_case(25, 2, 15, 1'b0);

        // Timeout with no valid sample at all, zero porch.
        vld_q.delete(); err_q.delete();
        push_const(30, 1'b0, 0, 0, 0);
        run_case(25, 0, 20, 1'b0);

        // Start issued in DONE is ignored; abort in IDLE keeps settle_time.
        vld_q.delete(); err_q.delete();
        push_const(1 + 16 + 4, 1'b1, 0, 0, 0);
        run_case(25, 0, 0, 1'b1);
        pulse_abort();
        chk("abort_idle_settled", int'(settled), 0);
        chk("abort_keeps_settle_time", int'(settle_time), last_e.stime);

        // Abort mid-WATCH: no done, flags cleared.
        @(posedge clk); #1;
        start = 1'b1; limit = 25; porch_cycles = 3; timeout_cycles = 0;
        @(posedge clk); #1;
        start = 1'b0; err_vld = 1'b1; err = '0;
        err[WIDTH +: WIDTH] = 13'd300;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; err_vld = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_settled", int'(settled), 0);
        chk("abort_timed_out", int'(timed_out), 0);
        chk("abort_ch_fail", int'(ch_fail), 0);
        repeat (30) @(posedge clk);
        #1;
        // Abort beats a simultaneous start in IDLE.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_over_start_busy", int'(busy), 0);

        // Hysteresis pattern: one sample of 10 then 28 repeated, limit 20.
        vld_q.delete(); err_q.delete();
        push_const(4, 1'b1, 10, 0, 0);
        push_const(120, 1'b1, 28, 0, 0);
        run_case(20, 2, 100, 1'b0);

        // Long porch saturates settle_time.
        vld_q.delete(); err_q.delete();
        push_const(4101 + 16 + 3, 1'b1, 0, 0, 0);
        run_case(25, 4100, 0, 1'b0);

        // Asynchronous reset mid-run.
        @(posedge clk); #1;
        start = 1'b1; limit = 25; porch_cycles = 2; timeout_cycles = 0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_settle_time", int'(settle_time), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomised runs.
        for (int r = 0; r < 25; r++) begin
            int lim   = $urandom_range(300);
            int porch = $urandom_range(20);
            int tmo   = $urandom_range(10, 120);
            vld_q.delete(); err_q.delete();
            gen_random(porch + 1 + tmo + 3, lim, $urandom_range(6, 20), $urandom_range(70, 100));
            run_case(lim, porch, tmo, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
